// File: rtl/loader_dma_if.sv
// Bus bundle between the serial loader and its host side: grant/done, UART RX/TX and the
// shared memory write port.
interface loader_dma_if #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 32,
  parameter int N_TARGETS  = 2
);
  localparam int TSEL_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;

  // Handshakes: rx_ready_i is a one-cycle valid strobe with no back-pressure (a byte
  // offered in a state that does not consume it is lost); tx_start_o is a one-cycle request
  // answered by a one-cycle tx_done_i; mem_we_o is a one-cycle, one-hot, always-accepted write.
  logic                    grant_i;
  logic [TSEL_W-1:0]       target_select_i;
  logic                    done_o;
  logic                    error_o;
  logic [7:0]              rx_data_i;
  logic                    rx_ready_i;
  logic [7:0]              tx_data_o;
  logic                    tx_start_o;
  logic                    tx_done_i;
  logic [N_TARGETS-1:0]    mem_we_o;
  logic [ADDR_W-1:0]       mem_addr_o;
  logic [8*WORD_BYTES-1:0] mem_data_o;
  logic [3:0]              state_o;

  modport master (
    output grant_i, target_select_i, rx_data_i, rx_ready_i, tx_done_i,
    input  done_o, error_o, tx_data_o, tx_start_o, mem_we_o, mem_addr_o, mem_data_o, state_o
  );

  modport slave (
    input  grant_i, target_select_i, rx_data_i, rx_ready_i, tx_done_i,
    output done_o, error_o, tx_data_o, tx_start_o, mem_we_o, mem_addr_o, mem_data_o, state_o
  );
endinterface

// File: rtl/loader_dma.sv
// UART-fed memory loader: receives a word count, a payload and an XOR checksum, writes the
// payload word by word into the selected target memory and answers with ACK or NACK.
module loader_dma #(
  parameter int         WORD_BYTES     = 4,
  parameter int         ADDR_W         = 32,
  parameter int         N_TARGETS      = 2,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE       = 8'hF1,
  parameter logic [7:0] NACK_CSUM      = 8'hE1,
  parameter logic [7:0] NACK_TMO       = 8'hE2
) (
  input logic         clk_i,
  input logic         rst_i,
  loader_dma_if.slave bus
);
  localparam int TSEL_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(WORD_BYTES - 1);
  localparam logic [IDLE_W-1:0] TMO_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SIZE_HI, S_SIZE_LO, S_RECV, S_WRITE, S_CSUM, S_SEND, S_WAIT_TX, S_DONE
  } state_t;

  state_t               state_q;
  logic [TSEL_W-1:0]    tsel_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BIDX_W-1:0]    bidx_q;
  logic [15:0]          words_q;
  logic [7:0]           csum_q;
  logic [DATA_W-1:0]    data_q;
  logic [IDLE_W-1:0]    idle_q;
  logic [N_TARGETS-1:0] we_q;
  logic [7:0]           tx_data_q;
  logic                 tx_start_q;
  logic                 nack_q;
  logic                 done_q;
  logic                 error_q;
  logic                 rx_state;

  assign rx_state = state_q inside {S_SIZE_HI, S_SIZE_LO, S_RECV, S_CSUM};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      tsel_q     <= '0;
      addr_q     <= '0;
      bidx_q     <= '0;
      words_q    <= '0;
      csum_q     <= '0;
      data_q     <= '0;
      idle_q     <= '0;
      we_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      we_q       <= '0;
      tx_start_q <= 1'b0;
      if (state_q != S_IDLE && !bus.grant_i) begin
        // Losing the grant abandons the transfer silently, including a finished one.
        state_q   <= S_IDLE;
        done_q    <= 1'b0;
        error_q   <= 1'b0;
        tx_data_q <= '0;
      end else if (rx_state && !bus.rx_ready_i && idle_q == TMO_LAST) begin
        state_q    <= S_SEND;
        tx_data_q  <= NACK_TMO;
        tx_start_q <= 1'b1;
        nack_q     <= 1'b1;
      end else begin
        if (rx_state) idle_q <= bus.rx_ready_i ? '0 : idle_q + IDLE_W'(1);
        case (state_q)
          S_IDLE: if (bus.grant_i) begin
            state_q <= S_SIZE_HI;
            tsel_q  <= bus.target_select_i;
            addr_q  <= '0;
            bidx_q  <= '0;
            words_q <= '0;
            csum_q  <= '0;
            idle_q  <= '0;
            nack_q  <= 1'b0;
          end
          S_SIZE_HI: if (bus.rx_ready_i) begin
            words_q[15:8] <= bus.rx_data_i;
            state_q       <= S_SIZE_LO;
          end
          S_SIZE_LO: if (bus.rx_ready_i) begin
            words_q[7:0] <= bus.rx_data_i;
            state_q      <= ({words_q[15:8], bus.rx_data_i} != 16'd0) ? S_RECV : S_CSUM;
          end
          S_RECV: if (bus.rx_ready_i) begin
            data_q[{bidx_q, 3'b000} +: 8] <= bus.rx_data_i;
            csum_q <= csum_q ^ bus.rx_data_i;
            if (bidx_q == BIDX_LAST) begin
              bidx_q  <= '0;
              we_q    <= N_TARGETS'(1) << tsel_q;
              state_q <= S_WRITE;
            end else begin
              bidx_q <= bidx_q + BIDX_W'(1);
            end
          end
          S_WRITE: begin
            addr_q <= addr_q + ADDR_W'(1);
            if (words_q == 16'd1) begin
              state_q <= S_CSUM;
            end else begin
              words_q <= words_q - 16'd1;
              state_q <= S_RECV;
            end
          end
          S_CSUM: if (bus.rx_ready_i) begin
            tx_data_q  <= (bus.rx_data_i == csum_q) ? ACK_BYTE : NACK_CSUM;
            nack_q     <= (bus.rx_data_i != csum_q);
            tx_start_q <= 1'b1;
            state_q    <= S_SEND;
          end
          S_SEND:    state_q <= S_WAIT_TX;
          S_WAIT_TX: if (bus.tx_done_i) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            error_q <= nack_q;
          end
          S_DONE:    state_q <= S_DONE;
          default:   state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Gating with the grant drops a write whose grant vanished in the WRITE cycle itself.
  assign bus.mem_we_o   = bus.grant_i ? we_q : '0;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign bus.tx_data_o  = tx_data_q;
  assign bus.tx_start_o = tx_start_q;
  assign bus.done_o     = done_q;
  assign bus.error_o    = error_q;
  assign bus.state_o    = state_q;
endmodule
